vga_pixel_fetch: RTL and testbench
==================================

Name: vga_pixel_fetch

Overview:
- Pixel stage directly downstream of vga_sync.
- Consumes the down-scaled raster position (pos_x/pos_y, 160x120 grid), blank_n and both syncs.
- Issues framebuffer reads for a double-buffered RGB332 framebuffer, expands the returned pixels to 8:8:8 for the VGA DAC, and delays the syncs and blank so they align with the pixel data.
- Hosts the front/back buffer swap handshake used by the GPU.

Parameters:
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
- ADDR_W, 16, framebuffer address width; must hold 2*FB_W*FB_H-1.
- RD_LAT, 1, framebuffer read latency in pixel-enable cycles (1..3).
- BORDER_RGB, 8'h00, RGB332 value shown for active pixels outside FB_W x FB_H.

Ports:
- clk0  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- clk_div2  in  1  pixel enable, one clk0 cycle high per pixel.
- pos_x  in  10  scaled column from vga_sync.
- pos_y  in  10  scaled row from vga_sync.
- blank_n_in  in  1  active-video flag from vga_sync.
- h_sync_in  in  1  hsync from vga_sync, active low.
- v_sync_in  in  1  vsync from vga_sync, active low.
- fb_rd_en  out  1  framebuffer read strobe.
- fb_addr  out  ADDR_W  framebuffer word address.
- fb_rdata  in  8  RGB332 pixel, valid RD_LAT enables after fb_rd_en.
- swap_req  in  1  one-cycle request to swap buffers at the next frame.
- swap_ack  out  1  one-cycle pulse when the swap takes effect.
- front_sel  out  1  buffer currently being displayed.
- vga_r  out  8  red.
- vga_g  out  8  green.
- vga_b  out  8  blue.
- vga_hs  out  1  aligned hsync.
- vga_vs  out  1  aligned vsync.
- vga_blank_n  out  1  aligned blank_n.

Behaviour:
- Reset: rst_n low asynchronously clears every register.
  - Outputs at reset: fb_rd_en=0, fb_addr=0, swap_ack=0, front_sel=0, vga_r/g/b=0, vga_hs=0, vga_vs=0, vga_blank_n=0.
  - All delay-line stages and the swap FSM reset to 0/IDLE.
  - Reset may be asserted at any time, including mid-line or mid-swap. After release, the first valid output appears after a full pipeline fill.
- All datapath registers advance only on clk0 edges with clk_div2=1 and hold otherwise. Exceptions: swap_ack and the swap FSM, which run every clk0 cycle.
- Stage 0, on an enable edge:
  - in_range = blank_n_in & (pos_x < FB_W) & (pos_y < FB_H).
  - fb_rd_en <= in_range.
  - fb_addr <= front_sel*FB_W*FB_H + pos_y*FB_W + pos_x, truncated to ADDR_W. Multiply by FB_W uses shifts/adds, no DSP: 160 = 128+32.
  - When in_range=0, fb_addr holds its previous value.
- The framebuffer RAM (outside this block) samples fb_addr/fb_rd_en and must present fb_rdata by the RD_LAT-th following enable. No stall path exists.
- Delay line: h_sync_in, v_sync_in, blank_n_in and in_range are delayed by RD_LAT+1 enable stages.
- Output stage, on the enable edge where the delayed in_range emerges:
  - Pixel source: fb_rdata if delayed in_range=1; BORDER_RGB if delayed blank_n=1 and in_range=0; if blank, r/g/b=0.
  - Expansion of pixel p: r = {p[7:5],p[7:5],p[7:6]}; g = {p[4:2],p[4:2],p[4:3]}; b = {p[1:0] x4}.
  - vga_hs/vga_vs/vga_blank_n are the delayed copies.
- Total latency, vga_sync inputs to vga_* outputs: RD_LAT+1 pixel enables (2 at default).
- Swap FSM, with states IDLE and PENDING:
  - IDLE -> PENDING on swap_req.
  - A vsync start is v_sync_in=1 on the previous enable and 0 on this enable, sampled on enables.
  - On a vsync start while PENDING, or while swap_req is high in the same cycle: toggle front_sel, pulse swap_ack for exactly one clk0 cycle, return to IDLE.
  - swap_req while PENDING is absorbed: one swap, one ack.
  - front_sel changes only at a vsync start, so a frame never mixes buffers.
  - Address uses the new front_sel from the next enable onward.
- Position wrap: pos_x/pos_y are unsigned. Values wrapped during blanking fail in_range and generate no read.

Test Plan:
- Reset: hold rst_n=0 mid-frame -> all outputs 0 asynchronously; after release with blank inputs, vga_blank_n stays 0 until 2 enables after blank_n_in rises.
- Addressing: front_sel=0, pos=(5,2) active -> fb_addr=325, fb_rd_en=1. Pos (159,119) -> 19199. Same pos with front_sel=1 -> 38399.
- Range/border: pos_x=160 or pos_y=120 with blank_n_in=1 -> fb_rd_en=0, output BORDER_RGB expanded. blank_n_in=0 -> rgb=0.
- Latency/colour: fb_rdata=8'hE3 for the pixel issued at enable N -> at enable N+2, vga_r=FF, vga_g=00, vga_b=FF, with vga_hs/vs/blank_n equal to the inputs at N. With clk_div2 held 0 for 10 clk0 cycles, all outputs are frozen.
- Swap: swap_req mid-frame -> no change until the next v_sync_in falling edge, then front_sel 0->1 and swap_ack high for 1 clk0 cycle. Two requests in one frame -> one toggle, one ack. swap_req coincident with the vsync edge -> swaps at that edge.
- Reset mid-swap: rst_n low while PENDING -> FSM IDLE, front_sel=0, and no swap_ack at the next vsync.

Source files
------------

// File: rtl/vga_pixel_fetch_if.sv
// Framebuffer read port between vga_pixel_fetch (master) and the
// framebuffer RAM (slave). The RAM samples fb_addr/fb_rd_en on pixel
// enables and returns the RGB332 word RD_LAT enables later.
interface vga_pixel_fetch_if #(
   parameter int ADDR_W = 16
);
   logic              fb_rd_en;
   logic [ADDR_W-1:0] fb_addr;
   logic [7:0]        fb_rdata;

   modport master (
      output fb_rd_en,
      output fb_addr,
      input  fb_rdata
   );

   modport slave (
      input  fb_rd_en,
      input  fb_addr,
      output fb_rdata
   );
endinterface

// File: rtl/vga_pixel_fetch.sv
// Pixel stage behind vga_sync: issues framebuffer reads for a
// double-buffered RGB332 framebuffer, expands returned pixels to 8:8:8,
// delays syncs/blank to line up with the pixel data, and owns the
// front/back buffer swap handshake with the GPU.
module vga_pixel_fetch #(
   parameter int         FB_W       = 160,
   parameter int         FB_H       = 120,
   parameter int         ADDR_W     = 16,
   parameter int         RD_LAT     = 1,
   parameter logic [7:0] BORDER_RGB = 8'h00
) (
   input  logic                     clk0,
   input  logic                     rst_n,
   input  logic                     clk_div2,
   input  logic [9:0]               pos_x,
   input  logic [9:0]               pos_y,
   input  logic                     blank_n_in,
   input  logic                     h_sync_in,
   input  logic                     v_sync_in,
   vga_pixel_fetch_if.master        fb,
   input  logic                     swap_req,
   output logic                     swap_ack,
   output logic                     front_sel,
   output logic [7:0]               vga_r,
   output logic [7:0]               vga_g,
   output logic [7:0]               vga_b,
   output logic                     vga_hs,
   output logic                     vga_vs,
   output logic                     vga_blank_n
);

   // Sideband delay depth: one stage for the address register plus RD_LAT
   // for the RAM, so the output register sees the pixel's own sideband.
   localparam int          DL          = RD_LAT + 1;
   localparam logic [9:0]  FB_W_L      = 10'(FB_W);
   localparam logic [9:0]  FB_H_L      = 10'(FB_H);
   localparam logic [19:0] FRAME_WORDS = 20'(FB_W * FB_H);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PENDING = 1'b1
   } swap_state_t;

   // Row offset: constant multiply unrolled into shifted adds of the set
   // bits of FB_W (160 = 128 + 32), so no multiplier is inferred.
   function automatic logic [19:0] mul_fb_w(input logic [9:0] v);
      logic [19:0] acc;
      acc = 20'd0;
      for (int i = 0; i < 10; i++) begin
         if (FB_W_L[i]) begin
            acc = acc + ({10'd0, v} << i);
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction

   // 3-bit channel to 8 bits by bit replication (full scale maps to 8'hFF).
   function automatic logic [7:0] exp3(input logic [2:0] c);
      return {c, c, c[2:1]};
   endfunction

   // 2-bit channel to 8 bits by bit replication.
   function automatic logic [7:0] exp2(input logic [1:0] c);
      return {c, c, c, c};
   endfunction

   logic              fb_rd_en_q;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic              in_range_s;
   logic [19:0]       addr_full_s;

   logic [DL-1:0]     hs_dly_q, vs_dly_q, bl_dly_q, rng_dly_q;

   logic [7:0]        pix_s;
   logic [7:0]        vga_r_q, vga_g_q, vga_b_q;
   logic [7:0]        vga_r_d, vga_g_d, vga_b_d;
   logic              vga_hs_q, vga_vs_q, vga_blank_n_q;

   swap_state_t       swap_state_q;
   logic              front_sel_q;
   logic              swap_ack_q;
   logic              vsync_start_s;

   // Stage-0 address generation and range test for the incoming position.
   always_comb begin
      in_range_s  = blank_n_in & (pos_x < FB_W_L) & (pos_y < FB_H_L);
      addr_full_s = (front_sel_q ? FRAME_WORDS : 20'd0)
                    + mul_fb_w(pos_y) + {10'd0, pos_x};
      if (in_range_s) begin
         fb_addr_d = ADDR_W'(addr_full_s);
      end else begin
         fb_addr_d = fb_addr_q;
      end
   end

   // Stage-0 read request register, advancing on pixel enables only.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         fb_rd_en_q <= 1'b0;
         fb_addr_q  <= '0;
      end else if (clk_div2) begin
         fb_rd_en_q <= in_range_s;
         fb_addr_q  <= fb_addr_d;
      end else begin
         fb_rd_en_q <= fb_rd_en_q;
         fb_addr_q  <= fb_addr_q;
      end
   end

   // Sideband delay line matching the framebuffer read path.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         hs_dly_q  <= '0;
         vs_dly_q  <= '0;
         bl_dly_q  <= '0;
         rng_dly_q <= '0;
      end else if (clk_div2) begin
         hs_dly_q  <= {hs_dly_q[DL-2:0],  h_sync_in};
         vs_dly_q  <= {vs_dly_q[DL-2:0],  v_sync_in};
         bl_dly_q  <= {bl_dly_q[DL-2:0],  blank_n_in};
         rng_dly_q <= {rng_dly_q[DL-2:0], in_range_s};
      end else begin
         hs_dly_q  <= hs_dly_q;
         vs_dly_q  <= vs_dly_q;
         bl_dly_q  <= bl_dly_q;
         rng_dly_q <= rng_dly_q;
      end
   end

   // Pixel source select and RGB332 -> 8:8:8 expansion.
   always_comb begin
      pix_s = 8'h00;
      if (rng_dly_q[DL-1]) begin
         pix_s = fb.fb_rdata;
      end else if (bl_dly_q[DL-1]) begin
         pix_s = BORDER_RGB;
      end else begin
         pix_s = 8'h00;
      end
      vga_r_d = exp3(pix_s[7:5]);
      vga_g_d = exp3(pix_s[4:2]);
      vga_b_d = exp2(pix_s[1:0]);
   end

   // Output register for colour and aligned syncs/blank.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         vga_r_q       <= 8'h00;
         vga_g_q       <= 8'h00;
         vga_b_q       <= 8'h00;
         vga_hs_q      <= 1'b0;
         vga_vs_q      <= 1'b0;
         vga_blank_n_q <= 1'b0;
      end else if (clk_div2) begin
         vga_r_q       <= vga_r_d;
         vga_g_q       <= vga_g_d;
         vga_b_q       <= vga_b_d;
         vga_hs_q      <= hs_dly_q[DL-1];
         vga_vs_q      <= vs_dly_q[DL-1];
         vga_blank_n_q <= bl_dly_q[DL-1];
      end else begin
         vga_r_q       <= vga_r_q;
         vga_g_q       <= vga_g_q;
         vga_b_q       <= vga_b_q;
         vga_hs_q      <= vga_hs_q;
         vga_vs_q      <= vga_vs_q;
         vga_blank_n_q <= vga_blank_n_q;
      end
   end

   // Vsync start: vs_dly_q[0] already holds v_sync_in from the previous
   // enable, so a falling edge is that bit high and the live input low.
   always_comb begin
      vsync_start_s = clk_div2 & vs_dly_q[0] & ~v_sync_in;
   end

   // Buffer swap FSM: runs every clk0 cycle; flips front_sel only at a
   // vsync start so a displayed frame never mixes buffers.
   always_ff @(posedge clk0 or negedge rst_n) begin
      if (!rst_n) begin
         swap_state_q <= S_IDLE;
         front_sel_q  <= 1'b0;
         swap_ack_q   <= 1'b0;
      end else begin
         swap_ack_q <= 1'b0;
         case (swap_state_q)
            S_IDLE: begin
               if (swap_req && vsync_start_s) begin
                  front_sel_q  <= ~front_sel_q;
                  swap_ack_q   <= 1'b1;
                  swap_state_q <= S_IDLE;
               end else if (swap_req) begin
                  swap_state_q <= S_PENDING;
               end else begin
                  swap_state_q <= S_IDLE;
               end
            end
            S_PENDING: begin
               // Further requests here are absorbed into the one swap.
               if (vsync_start_s) begin
                  front_sel_q  <= ~front_sel_q;
                  swap_ack_q   <= 1'b1;
                  swap_state_q <= S_IDLE;
               end else begin
                  swap_state_q <= S_PENDING;
               end
            end
            default: begin
               swap_state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign fb.fb_rd_en  = fb_rd_en_q;
   assign fb.fb_addr   = fb_addr_q;
   assign swap_ack     = swap_ack_q;
   assign front_sel    = front_sel_q;
   assign vga_r        = vga_r_q;
   assign vga_g        = vga_g_q;
   assign vga_b        = vga_b_q;
   assign vga_hs       = vga_hs_q;
   assign vga_vs       = vga_vs_q;
   assign vga_blank_n  = vga_blank_n_q;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Self-checking bench for vga_pixel_fetch: directed addressing, colour,
// border, freeze and swap scenarios, then randomized raster traffic, all
// compared against a cycle-level reference model of the block's rules.
module tb_vga_pixel_fetch;

   localparam int         LAT    = 2;       // RD_LAT + 1 at RD_LAT = 1
   localparam logic [7:0] BORDER = 8'h6D;

   logic       clk0 = 1'b0;
   logic       rst_n;
   logic       clk_div2;
   logic [9:0] pos_x, pos_y;
   logic       blank_n_in, h_sync_in, v_sync_in;
   logic       swap_req;
   logic       swap_ack, front_sel;
   logic [7:0] vga_r, vga_g, vga_b;
   logic       vga_hs, vga_vs, vga_blank_n;

   vga_pixel_fetch_if #(.ADDR_W(16)) fb_if ();

   vga_pixel_fetch #(
      .FB_W(160), .FB_H(120), .ADDR_W(16), .RD_LAT(1), .BORDER_RGB(BORDER)
   ) dut (
      .clk0(clk0), .rst_n(rst_n), .clk_div2(clk_div2),
      .pos_x(pos_x), .pos_y(pos_y),
      .blank_n_in(blank_n_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .fb(fb_if.master),
      .swap_req(swap_req), .swap_ack(swap_ack), .front_sel(front_sel),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
   );

   always #5 clk0 = ~clk0;

   // Framebuffer RAM with one-enable read latency.
   logic [7:0] mem [0:65535];
   always @(posedge clk0) begin
      if (clk_div2 && fb_if.fb_rd_en) fb_if.fb_rdata <= mem[fb_if.fb_addr];
   end

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // ---------------- reference model ----------------
   logic        m_front, m_pend, m_vs_prev, m_ack, m_rd_en;
   logic [15:0] m_addr;
   logic [7:0]  m_r, m_g, m_b;
   logic        m_hs, m_vs, m_bl;
   logic        h_rng [LAT];
   logic        h_bl  [LAT];
   logic        h_hs  [LAT];
   logic        h_vs  [LAT];
   logic [15:0] h_addr[LAT];

   // Rounded linear scaling of a channel to 0..255.
   function automatic logic [23:0] expand(input logic [7:0] p);
      int r3, g3, b2;
      r3 = int'(p[7:5]);
      g3 = int'(p[4:2]);
      b2 = int'(p[1:0]);
      return {8'((r3 * 255 + 3) / 7), 8'((g3 * 255 + 3) / 7), 8'(b2 * 85)};
   endfunction

   task automatic model_clear();
      m_front = 0; m_pend = 0; m_vs_prev = 0; m_ack = 0; m_rd_en = 0;
      m_addr = 0; m_r = 0; m_g = 0; m_b = 0; m_hs = 0; m_vs = 0; m_bl = 0;
      for (int i = 0; i < LAT; i++) begin
         h_rng[i] = 0; h_bl[i] = 0; h_hs[i] = 0; h_vs[i] = 0; h_addr[i] = 0;
      end
   endtask

   task automatic compare_all();
      chk("fb_rd_en", fb_if.fb_rd_en, m_rd_en);
      chk("fb_addr", fb_if.fb_addr, m_addr);
      chk("swap_ack", swap_ack, m_ack);
      chk("front_sel", front_sel, m_front);
      chk("vga_r", vga_r, m_r);
      chk("vga_g", vga_g, m_g);
      chk("vga_b", vga_b, m_b);
      chk("vga_hs", vga_hs, m_hs);
      chk("vga_vs", vga_vs, m_vs);
      chk("vga_blank_n", vga_blank_n, m_bl);
   endtask

   // One clk0 cycle: drive inputs, predict the edge, check after it.
   task automatic step(input logic en, input logic [9:0] x, input logic [9:0] y,
                       input logic bl, input logic hs, input logic vs, input logic req);
      logic        rng, vs_start;
      logic [7:0]  p;
      logic [23:0] rgb;
      int          a;
      @(negedge clk0);
      clk_div2 = en; pos_x = x; pos_y = y;
      blank_n_in = bl; h_sync_in = hs; v_sync_in = vs; swap_req = req;
      vs_start = en && m_vs_prev && !vs;
      if (en) begin
         rng = bl && (x < 10'd160) && (y < 10'd120);
         if (h_rng[LAT-1]) p = mem[h_addr[LAT-1]];
         else if (h_bl[LAT-1]) p = BORDER;
         else p = 8'h00;
         rgb = h_bl[LAT-1] ? expand(p) : 24'h0;
         m_r = rgb[23:16]; m_g = rgb[15:8]; m_b = rgb[7:0];
         m_hs = h_hs[LAT-1]; m_vs = h_vs[LAT-1]; m_bl = h_bl[LAT-1];
         a = (m_front ? 19200 : 0) + int'(y) * 160 + int'(x);
         for (int i = LAT - 1; i > 0; i--) begin
            h_rng[i] = h_rng[i-1]; h_bl[i] = h_bl[i-1]; h_hs[i] = h_hs[i-1];
            h_vs[i] = h_vs[i-1]; h_addr[i] = h_addr[i-1];
         end
         h_rng[0] = rng; h_bl[0] = bl; h_hs[0] = hs; h_vs[0] = vs; h_addr[0] = a[15:0];
         m_rd_en = rng;
         if (rng) m_addr = a[15:0];
         m_vs_prev = vs;
      end
      m_ack = vs_start && (m_pend || req);
      if (m_ack) begin
         m_front = !m_front;
         m_pend  = 0;
      end else if (req) begin
         m_pend = 1;
      end
      @(posedge clk0);
      #1;
      compare_all();
   endtask

   // One pixel: an enable cycle followed by an idle cycle.
   task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic bl,
                      input logic hs, input logic vs, input logic req);
      step(1'b1, x, y, bl, hs, vs, req);
      step(1'b0, x, y, bl, hs, vs, 1'b0);
   endtask

   // Asynchronous reset asserted mid-cycle, outputs checked while held.
   task automatic do_reset();
      @(negedge clk0);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      compare_all();
      clk_div2 = 1'b0; swap_req = 1'b0;
      repeat (2) @(negedge clk0);
      rst_n = 1'b1;
   endtask

   initial begin
      int vcnt;
      logic [9:0] rx, ry;
      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      mem[325] = 8'hE3;
      rst_n = 1'b0; clk_div2 = 1'b0; pos_x = 10'd0; pos_y = 10'd0;
      blank_n_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; swap_req = 1'b0;
      model_clear();
      repeat (3) @(negedge clk0);
      rst_n = 1'b1;

      // Mid-frame reset, then blank lead-in before active video.
      pix(10'd3, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      pix(10'd4, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) pix(10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);

      // Addressing and colour expansion.
      pix(10'd5, 10'd2, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("addr_5_2", fb_if.fb_addr, 32'd325);
      chk("rd_en_5_2", fb_if.fb_rd_en, 32'd1);
      pix(10'd159, 10'd119, 1'b1, 1'b0, 1'b1, 1'b0);
      chk("addr_159_119", fb_if.fb_addr, 32'd19199);
      pix(10'd160, 10'd3, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("e3_r", vga_r, 32'hFF);
      chk("e3_g", vga_g, 32'h00);
      chk("e3_b", vga_b, 32'hFF);
      chk("e3_hs", vga_hs, 32'd1);
      pix(10'd7, 10'd120, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("rd_en_oob", fb_if.fb_rd_en, 32'd0);
      chk("addr_hold", fb_if.fb_addr, 32'd19199);
      pix(10'd8, 10'd8, 1'b0, 1'b1, 1'b1, 1'b0);
      pix(10'd9, 10'd8, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("border_r", vga_r, 32'h6D);
      pix(10'd10, 10'd8, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("blank_rgb", {8'h0, vga_r, vga_g, vga_b}, 32'h0);

      // Pixel enable held low: everything frozen.
      for (int i = 0; i < 10; i++)
         step(1'b0, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);

      // Swap requested mid-frame, taken at the next vsync start.
      pix(10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) pix(10'(i), 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("front_wait", front_sel, 32'd0);
      step(1'b1, 10'd2, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ack_pulse", swap_ack, 32'd1);
      step(1'b0, 10'd2, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ack_one_cycle", swap_ack, 32'd0);
      chk("front_1", front_sel, 32'd1);
      pix(10'd159, 10'd119, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("addr_front1", fb_if.fb_addr, 32'd38399);

      // Two requests in one frame -> a single swap.
      pix(10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1);
      pix(10'd2, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 10'd2, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1);
      pix(10'd3, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      pix(10'd3, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      pix(10'd3, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("front_two_req", front_sel, 32'd0);

      // Request coincident with the vsync start.
      pix(10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      pix(10'd1, 10'd1, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("front_coincident", front_sel, 32'd1);

      // Randomized raster traffic with sporadic swap requests.
      vcnt = 0;
      for (int n = 0; n < 1500; n++) begin
         vcnt++;
         if ($urandom_range(0, 15) == 0) rx = 10'($urandom);
         else rx = 10'($urandom_range(0, 170));
         ry = 10'($urandom_range(0, 125));
         step(1'b1, rx, ry, ($urandom_range(0, 9) != 0), ((vcnt % 20) >= 2),
              ((vcnt % 60) >= 4), ($urandom_range(0, 39) == 0));
         for (int g = 0; g < int'($urandom_range(0, 2)); g++)
            step(1'b0, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 39) == 0));
      end

      // Reset while a swap is pending: the request is lost.
      pix(10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      pix(10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b1);
      do_reset();
      pix(10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      pix(10'd1, 10'd1, 1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b1, 10'd1, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("no_ack_after_rst", swap_ack, 32'd0);
      step(1'b0, 10'd1, 10'd1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("front_after_rst", front_sel, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
